// File: rtl/round_robin_m2s_wr_pkg.sv
// Shared types and constants for the four-master AXI write-path arbiter.
package m2s_wr_pkg;
   localparam int NUM_M       = 4;
   localparam int IDX_W       = 2;
   localparam int BURST_LEN_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_e;
endpackage

// File: rtl/round_robin_m2s_wr_pick.sv
// Combinational rotating-priority picker: searches from last+1 upward, wrapping.
module m2s_rr_pick
   import m2s_wr_pkg::*;
(
   input  logic [NUM_M-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [NUM_M-1:0] pick_o,
   output logic [IDX_W-1:0] idx_o
);
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      cand   = '0;
      // k == NUM_M wraps back to last itself, so it is checked last
      for (int k = 1; k <= NUM_M; k++) begin
         cand = last_i + IDX_W'(k);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            pick_o[cand] = 1'b1;
            idx_o        = cand;
         end
      end
   end
endmodule

// File: rtl/round_robin_m2s_wr.sv
// Four-master to one-slave AXI write arbiter; grant held from AW accept through B.
module round_robin_m2s_wr
   import m2s_wr_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_M-1:0]          m_awvalid,
   output logic [NUM_M-1:0]          m_awready,
   input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
   input  logic [NUM_M*8-1:0]        m_awlen,
   input  logic [NUM_M-1:0]          m_wvalid,
   output logic [NUM_M-1:0]          m_wready,
   input  logic [NUM_M*DATA_W-1:0]   m_wdata,
   input  logic [NUM_M*STRB_W-1:0]   m_wstrb,
   input  logic [NUM_M-1:0]          m_wlast,
   output logic [NUM_M-1:0]          m_bvalid,
   input  logic [NUM_M-1:0]          m_bready,
   output logic [1:0]                m_bresp,
   output logic                      s_awvalid,
   input  logic                      s_awready,
   output logic [ADDR_W-1:0]         s_awaddr,
   output logic [7:0]                s_awlen,
   output logic                      s_wvalid,
   input  logic                      s_wready,
   output logic [DATA_W-1:0]         s_wdata,
   output logic [STRB_W-1:0]         s_wstrb,
   output logic                      s_wlast,
   input  logic                      s_bvalid,
   output logic                      s_bready,
   input  logic [1:0]                s_bresp,
   output logic [NUM_M-1:0]          grant,
   output logic                      err_wlast
);
   state_e                 state_q, state_d;
   logic [NUM_M-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [BURST_LEN_W-1:0] cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [NUM_M-1:0]       pick;
   logic [IDX_W-1:0]       pick_idx;

   m2s_rr_pick u_pick (
      .req_i  (m_awvalid),
      .last_i (last_q),
      .pick_o (pick),
      .idx_o  (pick_idx)
   );

   // last_q doubles as the owner index while a transaction is in flight
   always_comb begin
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_awlen   = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      s_bready  = 1'b0;
      case (state_q)
         ADDR: begin
            s_awvalid         = m_awvalid[last_q];
            s_awaddr          = m_awaddr[last_q*ADDR_W +: ADDR_W];
            s_awlen           = m_awlen[last_q*8 +: 8];
            m_awready[last_q] = s_awready;
         end
         DATA: begin
            s_wvalid         = m_wvalid[last_q];
            s_wdata          = m_wdata[last_q*DATA_W +: DATA_W];
            s_wstrb          = m_wstrb[last_q*STRB_W +: STRB_W];
            s_wlast          = m_wlast[last_q];
            m_wready[last_q] = s_wready;
         end
         RESP: begin
            m_bvalid[last_q] = s_bvalid;
            s_bready         = m_bready[last_q];
            m_bresp          = s_bresp;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (|m_awvalid) begin
               grant_d = pick;
               last_d  = pick_idx;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (s_awvalid && s_awready) begin
               cnt_d   = s_awlen;
               state_d = DATA;
            end
         end
         DATA: begin
            if (s_wvalid && s_wready) begin
               // the beat counter ends the burst; wlast is only audited
               if (s_wlast != (cnt_q == '0)) err_d = 1'b1;
               if (cnt_q == '0) state_d = RESP;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (s_bvalid && s_bready) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_M - 1);
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign grant     = grant_q;
   assign err_wlast = err_q;
endmodule

// File: doc/round_robin_m2s_wr.md
Name: round_robin_m2s_wr

Overview:
Master-to-slave write-path arbiter for the AXI interconnect. It arbitrates four master write ports onto one slave write port, round-robin. The grant is locked for the whole write transaction: AW accept, every W beat, then the B response. After the B handshake the grant is released. One write is outstanding at a time. This block pairs with the existing slave-to-master arbitration path.

Parameters:
ADDR_W, 32, AW address width per master
DATA_W, 32, W data width per master
STRB_W, DATA_W/8, W strobe width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
m_awvalid  in  4  per-master AW valid
m_awready  out  4  per-master AW ready
m_awaddr  in  4*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
m_awlen  in  4*8  packed burst length-1
m_wvalid  in  4  per-master W valid
m_wready  out  4  per-master W ready
m_wdata  in  4*DATA_W  packed
m_wstrb  in  4*STRB_W  packed
m_wlast  in  4  per-master W last
m_bvalid  out  4  per-master B valid
m_bready  in  4  per-master B ready
m_bresp  out  2  B response, broadcast; qualified by m_bvalid
s_awvalid/s_awready/s_awaddr/s_awlen  out/in/out/out  1/1/ADDR_W/8  slave AW channel
s_wvalid/s_wready/s_wdata/s_wstrb/s_wlast  out/in/out/out/out  1/1/DATA_W/STRB_W/1  slave W channel
s_bvalid/s_bready/s_bresp  in/out/in  1/1/2  slave B channel
grant  out  4  one-hot current owner; 0 in IDLE
err_wlast  out  1  sticky: m_wlast disagreed with beat count

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, grant=0, last pointer=3 (master 0 highest priority first), beat counter=0, err_wlast=0.
  - All ready/valid outputs are 0 and all muxed data outputs are 0.
- States: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - All m_*ready, m_bvalid, s_awvalid, s_wvalid and s_bready are 0.
  - If any m_awvalid is 1, pick a winner by rotating priority starting at last+1 and wrapping 3->0.
  - Register grant (one-hot) and last<=winner, then go to ADDR. Arbitration latency is one cycle.
  - No m_awvalid: remain in IDLE, last pointer unchanged.
- ADDR:
  - s_awvalid=m_awvalid[g]; s_awaddr/s_awlen are muxed from master g; m_awready[g]=s_awready; other m_awready are 0.
  - On s_awvalid&&s_awready: load counter=s_awlen, go to DATA.
  - If m_awvalid[g] drops, stay in ADDR with no re-arbitration.
- DATA:
  - s_wvalid=m_wvalid[g]; wdata/wstrb/wlast are muxed from master g; m_wready[g]=s_wready.
  - W beats presented before DATA see wready=0.
  - Each handshake decrements the counter. The handshake at counter==0 ends the burst (the counter is authoritative) and moves to RESP.
  - If m_wlast[g] differs from (counter==0) on any handshake, set err_wlast (cleared only by rst).
  - awlen=0 gives a single beat.
- RESP:
  - m_bvalid[g]=s_bvalid; s_bready=m_bready[g]; m_bresp=s_bresp.
  - On handshake: grant<=0, go to IDLE.
  - Minimum one IDLE cycle between transactions.
- Non-granted masters always see ready=0 and bvalid=0.
- Reset asserted mid-burst aborts immediately. The slave sees valids drop asynchronously and no completion.
- All outputs in non-IDLE states are combinational from the registered state and grant only; no input-to-grant path.

Decomposition:
- Package m2s_wr_pkg:
  - state enum (IDLE, ADDR, DATA, RESP), 2-bit encoding.
  - NUM_M=4.
  - BURST_LEN_W=8.
- Sub-module m2s_rr_pick: combinational 4-way rotating-priority picker. Inputs are req[3:0] and last[1:0]; outputs are one-hot pick and an index.

Test Plan:
- Reset release, only m_awvalid[2]=1 with awlen=3 -> grant=4'b0100 the cycle after; 4 W beats pass; err_wlast stays 0; B returns on m_bvalid[2] only; grant returns to 0.
- All four m_awvalid=1 continuously, single-beat bursts -> grant order 0,1,2,3,0; one IDLE cycle between each.
- Master 1 drives wvalid before its AW is accepted -> m_wready[1]=0 until DATA; s_wvalid stays 0 in ADDR.
- awlen=2 with m_wlast asserted on beat 1 -> burst still ends after beat 3; err_wlast=1 and stays high.
- s_awready held 0 for 5 cycles while master 3 wins and masters 0/2 request -> grant stays 4'b1000 throughout; no re-arbitration.
- rst pulsed during DATA beat 2 of 4 -> grant=0 and s_wvalid=0 immediately; next arbitration starts at master 0.
